// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
// Bus between the decode/writeback stages and the register file scoreboard.
//
// Parameters:
//   XLEN   - data width of each register
//   ADDR_W - register address width (register count is 2**ADDR_W)
//
// Signals:
//   instruction  - 32-bit instruction word (rs1/rs2/rd fields decoded inside)
//   read_en      - operand read request, also qualifies the hazard check
//   issue_en     - instruction issuing this cycle, marks rd pending
//   wb_en        - writeback valid
//   wb_addr      - writeback register
//   wb_data      - writeback value
//   read_data1   - rs1 operand
//   read_data2   - rs2 operand
//   stall        - RAW/WAW hazard, issue must not proceed
//   pend_cnt     - number of registers with an outstanding writeback
//
// Modports:
//   master - the pipeline side driving requests
//   slave  - the register file
interface reg_file_sb_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
);
  logic [31:0]       instruction;
  logic              read_en;
  logic              issue_en;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic [XLEN-1:0]   read_data1;
  logic [XLEN-1:0]   read_data2;
  logic              stall;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output instruction, read_en, issue_en, wb_en, wb_addr, wb_data,
    input  read_data1, read_data2, stall, pend_cnt
  );

  modport slave (
    input  instruction, read_en, issue_en, wb_en, wb_addr, wb_data,
    output read_data1, read_data2, stall, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Integer register file with a per-register write-pending scoreboard for the
// decode/writeback boundary. Register 0 is hardwired to zero and never busy.
// Read operands and stall are combinational; all state updates on the rising
// edge of clk and clears asynchronously on rst_n low.
//
// Parameters:
//   XLEN   - data width of each register (default 64)
//   ADDR_W - register address width, 1..5 (default 5), NREG = 2**ADDR_W
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - reg_file_sb_if.slave (instruction, read/issue/writeback
//           controls, read operands, stall, pend_cnt)
//
// Optional feature:
//   REG_FILE_SB_BYPASS_EN - when defined, a writeback in the current cycle is
//   forwarded to a matching read operand and suppresses that operand's RAW
//   hazard. When undefined, reads come from storage only.
module reg_file_sb #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   busy;
  logic [ADDR_W:0]   pend_q;

  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;

  logic              wb_hit;
  logic              byp1;
  logic              byp2;
  logic              stall;
  logic              set_eff;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [XLEN-1:0]   rdata1;
  logic [XLEN-1:0]   rdata2;

  assign rs1 = bus.instruction[15 +: ADDR_W];
  assign rs2 = bus.instruction[20 +: ADDR_W];
  assign rd  = bus.instruction[7 +: ADDR_W];

  // Opcode/funct bits are not needed here; folding them keeps them visibly consumed.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction;

  assign wb_hit = bus.wb_en && (bus.wb_addr != '0);

`ifdef REG_FILE_SB_BYPASS_EN
  assign byp1 = wb_hit && (bus.wb_addr == rs1);
  assign byp2 = wb_hit && (bus.wb_addr == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Operands read as zero when not requested or when addressing x0.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (bus.read_en) begin
      if (rs1 != '0) rdata1 = byp1 ? bus.wb_data : regs[rs1];
      if (rs2 != '0) rdata2 = byp2 ? bus.wb_data : regs[rs2];
    end
  end

  // RAW terms may be forwarded away; the WAW term on rd never is.
  always_comb begin
    stall = bus.read_en &&
            ((busy[rs1] && (rs1 != '0) && !byp1) ||
             (busy[rs2] && (rs2 != '0) && !byp2) ||
             (busy[rd]  && (rd  != '0)));
  end

  // The counter tracks busy-bit transitions. When issue and writeback hit the
  // same register the bit stays set, so only a previously idle bit counts up.
  always_comb begin
    set_eff = bus.issue_en && !stall && (rd != '0);
    cnt_inc = set_eff && !busy[rd];
    cnt_dec = wb_hit && busy[bus.wb_addr] &&
              !(set_eff && (rd == bus.wb_addr));
  end

  assign bus.read_data1 = rdata1;
  assign bus.read_data2 = rdata2;
  assign bus.stall      = stall;
  assign bus.pend_cnt   = pend_q;

  // Register storage; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard bits; the set follows the clear so a new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wb_hit)  busy[bus.wb_addr] <= 1'b0;
      if (set_eff) busy[rd]          <= 1'b1;
    end
  end

  // Pending counter, updated on the same edge as the busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   pend_q <= pend_q + CNT_ONE;
        2'b01:   pend_q <= pend_q - CNT_ONE;
        default: pend_q <= pend_q;
      endcase
    end
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with per-register write-pending scoreboard, for the decode/writeback boundary of the CPU pipeline.
- Decodes rs1/rs2/rd from the 32-bit instruction word and returns two combinational read operands.
- Tracks destinations with an outstanding writeback and raises `stall` on RAW/WAW hazards.
- Register 0 is hardwired to zero; optional writeback-to-read bypass.

## Interface
Parameters:
- `XLEN`, 64, data width of each register.
- `ADDR_W`, 5, register address width, legal range 1..5; register count `NREG = 2**ADDR_W`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instruction`  in  32  decoded fields:
  - rs1 = `instruction[15 +: ADDR_W]`
  - rs2 = `instruction[20 +: ADDR_W]`
  - rd = `instruction[7 +: ADDR_W]`
- `read_en`  in  1  operand read request; also qualifies hazard check.
- `issue_en`  in  1  instruction issuing this cycle; marks rd pending.
- `wb_en`  in  1  writeback valid.
- `wb_addr`  in  ADDR_W  writeback register.
- `wb_data`  in  XLEN  writeback value.
- `read_data1`  out  XLEN  rs1 operand.
- `read_data2`  out  XLEN  rs2 operand.
- `stall`  out  1  hazard; issue must not proceed.
- `pend_cnt`  out  ADDR_W+1  number of registers currently pending.

## Operation
- Storage: `NREG` x `XLEN` registers plus `NREG` busy bits. Entry 0 is never written; it reads 0 and is never busy.
- Read: when `read_en`=0, both read outputs are 0. When `read_en`=1, each read output is the addressed register, or 0 for address 0.
- Write: on edge with `wb_en`=1 and `wb_addr`!=0, `regs[wb_addr]` <= `wb_data` and `busy[wb_addr]` <= 0. Writes to address 0 are ignored.
- `stall` = `read_en` & (hz(rs1) | hz(rs2) | hz_w(rd)), where:
  - hz(a) = `busy[a]` & a!=0, excluding the bypass case (see Configuration).
  - hz_w(rd) = `busy[rd]` & rd!=0 (WAW). This term is never bypassed.
- Issue: on edge with `issue_en`=1, `stall`=0 and rd!=0, `busy[rd]` <= 1. An `issue_en` asserted while `stall`=1 is ignored and has no state effect.
- Simultaneous issue and writeback:
  - Same address in one edge: the register data is written and the busy bit ends at 1 (new producer wins).
  - Different addresses: both take effect.
- `pend_cnt` = population of busy bits, maintained as a registered counter. Per edge: +1 on an effective set of a non-busy bit, -1 on a clear of a busy bit, net 0 when both occur.
  - Never exceeds `NREG`-1.
  - A writeback to a non-busy register writes data and does not decrement.
- Reset (asserted at any time, including mid-operation): all registers and busy bits clear to 0 and `pend_cnt` goes to 0 immediately. A writeback or issue coinciding with reset is lost.

## Timing
- `read_data1`, `read_data2`, `stall`: combinational from `instruction`, `read_en`, the state, and (with bypass) `wb_*`. Zero-cycle latency.
- Write-to-read latency:
  - Without bypass: 1 cycle; the value is visible the cycle after the write edge.
  - With bypass: 0 cycles.
- Busy set by issue at edge N: a dependent read at cycle N+1 stalls.
- Values after reset release: all outputs 0 (`read_data*` = 0 for any address, `stall`=0, `pend_cnt`=0).
- `pend_cnt` updates on the same edge as the busy bits.

## Configuration
- Macro `REG_FILE_SB_BYPASS_EN`.
- When defined: if `wb_en`=1, `wb_addr`!=0 and `wb_addr` equals rs1 (or rs2), that read output returns `wb_data` in the same cycle. hz() for that operand is then 0, so a RAW on the register being written back does not stall.
- When undefined: read outputs come from storage only. A busy operand stalls until the edge after its writeback.

## Test plan
- Reset clear: hold `rst_n`=0 mid-stream with `pend_cnt`=3 -> `pend_cnt`=0, `stall`=0, all reads 0 after release.
- x0 behaviour: writeback `wb_addr`=0, `wb_data`=64'hDEAD -> rs1=0 reads 0; issue with rd=0 leaves `pend_cnt` unchanged.
- RAW stall: issue rd=5, next cycle read rs1=5 -> `stall`=1; write x5=64'h1234 -> next cycle `stall`=0, `read_data1`=64'h1234, `pend_cnt` back to 0.
- Bypass: rd=7 busy, same-cycle `wb_addr`=7, `wb_data`=64'hCAFE with rs2=7.
  - `REG_FILE_SB_BYPASS_EN` defined -> `read_data2`=64'hCAFE, `stall`=0.
  - Undefined -> `stall`=1.
- Simultaneous set/clear: x9 busy; issue rd=9 (not stalled because `read_en`=0) and wb x9=64'h55 on the same edge -> x9 reads 64'h55, `busy[9]`=1, `pend_cnt` unchanged.
- WAW plus parameters: rd=3 busy, issue rd=3 with `read_en`=1 -> `stall`=1, no state change. Repeat with `ADDR_W`=3, `XLEN`=32: rd field `instruction[9:7]`, 8 registers.
